// File: rtl/cos_poly_eval.sv
// cos_poly_eval
//   Consumer side of the cosine coefficient ROM in the Box-Muller datapath.
//   A 16-bit phase word u is folded into the first quadrant. The folded
//   segment drives the ROM address. The degree-1 segment polynomial
//   c0 + c1*xb is then evaluated and emitted as a signed Q1.15 cos(2*pi*u).
//
// Ports
//   clock      system clock, all state on the rising edge
//   reset      asynchronous, active-high reset
//   in_valid   phase word valid
//   in_ready   block can accept a phase word this cycle
//   u[15:0]    phase: [15:14] quadrant, [13:7] segment, [6:0] offset
//   rom_addr   coefficient ROM read address (combinational)
//   rom_c1     ROM slope, registered inside the ROM (1-cycle latency)
//   rom_c0     ROM intercept, registered inside the ROM (1-cycle latency)
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   cos_out    signed Q1.15 result
//
// Build option
//   COS_POLY_ROUND_EN  when defined, round half up before the final shift.
//                      When undefined, the result is truncated.
//                      Latency is the same in both builds.
module cos_poly_eval #(
  parameter int ROUND_BITS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] u,
  output logic [6:0]  rom_addr,
  input  logic [11:0] rom_c1,
  input  logic [18:0] rom_c0,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] cos_out
);

  // Saturating magnitude extraction from the 20-bit accumulated sum.
  function automatic logic [14:0] sat_mag(input logic [19:0] sum);
    logic [19:0] s;
`ifdef COS_POLY_ROUND_EN
    s = sum + (20'd1 << (ROUND_BITS - 1));
`else
    s = sum;
`endif
    if (s[19]) sat_mag = 15'h7FFF;
    else       sat_mag = 15'(s >> ROUND_BITS);
  endfunction

  // Sign application. The magnitude is at most 0x7FFF, so 0x8000 never appears.
  function automatic logic signed [15:0] apply_sign(input logic [14:0] mag,
                                                     input logic neg);
    logic signed [15:0] m;
    m = signed'({1'b0, mag});
    apply_sign = neg ? -m : m;
  endfunction

  logic              stall;
  logic              accept;

  logic [6:0]        addr_p0;
  logic [6:0]        x_p0;
  logic              neg_p0;

  logic              vld_p1;
  logic [6:0]        addr_p1;
  logic [6:0]        x_p1;
  logic              neg_p1;

  logic              vld_p2;
  logic [6:0]        addr_p2;
  logic [6:0]        x_p2;
  logic              neg_p2;

  logic [18:0]       prod_p2;
  logic [19:0]       sum_p2;

  logic              vld_p3;
  logic [19:0]       sum_p3;
  logic              neg_p3;

  logic              vld_p4;
  logic signed [15:0] cos_p4;

  assign stall     = vld_p4 & ~out_ready;
  assign in_ready  = ~stall;
  assign accept    = in_valid & in_ready;
  assign out_valid = vld_p4;
  assign cos_out   = cos_p4;

  // While stalled the ROM is re-addressed with the S2 address. This keeps its
  // registered output aligned with the sample held in S2.
  assign rom_addr = stall ? addr_p2 : addr_p1;

  // ---- Stage 0: quadrant fold. Odd quadrants mirror, quadrants 1 and 2 negate.
  always_comb begin
    addr_p0 = u[14] ? ~u[13:7] : u[13:7];
    x_p0    = u[14] ? ~u[6:0]  : u[6:0];
    neg_p0  = u[15] ^ u[14];
  end

  // ---- Stage 2 combinational: polynomial from the ROM data now aligned with S2.
  always_comb begin
    prod_p2 = 19'(rom_c1) * 19'(x_p2);
    sum_p2  = {1'b0, rom_c0} + 20'(prod_p2 >> ROUND_BITS);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      x_p1    <= '0;
      neg_p1  <= 1'b0;
      vld_p2  <= 1'b0;
      addr_p2 <= '0;
      x_p2    <= '0;
      neg_p2  <= 1'b0;
      vld_p3  <= 1'b0;
      sum_p3  <= '0;
      neg_p3  <= 1'b0;
      vld_p4  <= 1'b0;
      cos_p4  <= '0;
    end else if (!stall) begin
      // ---- Stage 1: folded address/offset. The ROM captures table(addr_p1)
      // on this same edge.
      vld_p1 <= accept;
      if (accept) begin
        addr_p1 <= addr_p0;
        x_p1    <= x_p0;
        neg_p1  <= neg_p0;
      end
      // ---- Stage 2: operands aligned with the ROM output.
      vld_p2  <= vld_p1;
      addr_p2 <= addr_p1;
      x_p2    <= x_p1;
      neg_p2  <= neg_p1;
      // ---- Stage 3: accumulated sum.
      vld_p3  <= vld_p2;
      sum_p3  <= sum_p2;
      neg_p3  <= neg_p2;
      // ---- Stage 4: saturated, signed output register.
      vld_p4  <= vld_p3;
      cos_p4  <= apply_sign(sat_mag(sum_p3), neg_p3);
    end
  end

endmodule

// File: tb/tb_cos_poly_eval.sv
module tb_cos_poly_eval;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] u = '0;
  logic [6:0]  rom_addr;
  logic [11:0] rom_c1 = '0;
  logic [18:0] rom_c0 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] cos_out;

  int errors = 0;
  int checks = 0;
  int rom_mode = 0;

  always #5 clock = ~clock;

  cos_poly_eval dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .u        (u),
    .rom_addr (rom_addr),
    .rom_c1   (rom_c1),
    .rom_c0   (rom_c0),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .cos_out  (cos_out)
  );

  // Bench coefficient ROM with a registered output (1-cycle latency).
  always_ff @(posedge clock) begin
    case (rom_mode)
      0: begin rom_c1 <= 12'h010; rom_c0 <= 19'h40000; end
      1: begin rom_c1 <= 12'hFFF; rom_c0 <= 19'h7FFFF; end
      2: begin rom_c1 <= 12'h010; rom_c0 <= {4'b0, rom_addr, 8'h00}; end
      default: begin rom_c1 <= 12'h000; rom_c0 <= 19'h40008; end
    endcase
  end

  // Sends one word while aligned at posedge+1. It checks the address and the
  // 3-edge latency, then the result.
  task automatic send_one(input logic [15:0] uin, input logic [6:0] exp_addr,
                          input logic [15:0] exp_cos, input string name);
    in_valid = 1'b1;
    u        = uin;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready: got %0b want 1", name, in_ready);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    checks++;
    if (rom_addr !== exp_addr) begin
      errors++; $display("FAIL %s rom_addr: got %h want %h", name, rom_addr, exp_addr);
    end
    for (int e = 1; e <= 3; e++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL %s early out_valid at edge k+%0d: got %0b want 0", name, e - 1, out_valid);
      end
      @(posedge clock); #1;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL %s out_valid at k+3: got %0b want 1", name, out_valid);
    end
    checks++;
    if (cos_out !== exp_cos) begin
      errors++; $display("FAIL %s cos_out: got %h want %h", name, cos_out, exp_cos);
    end
    @(posedge clock); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL %s drain out_valid: got %0b want 0", name, out_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %0b want 0", out_valid); end
    checks++;
    if (cos_out !== 16'h0000) begin errors++; $display("FAIL reset cos_out: got %h want 0000", cos_out); end
    checks++;
    if (rom_addr !== 7'h00) begin errors++; $display("FAIL reset rom_addr: got %h want 00", rom_addr); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %0b want 1", in_ready); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_basic;
    rom_mode = 0;
    send_one(16'h0000, 7'h00, 16'h4000, "basic");
  endtask

  task automatic test_mirror;
    rom_mode = 0;
`ifdef COS_POLY_ROUND_EN
    send_one(16'h4000, 7'h7F, 16'hBFF8, "mirror");
`else
    send_one(16'h4000, 7'h7F, 16'hBFF9, "mirror");
`endif
  endtask

  task automatic test_saturation;
    rom_mode = 1;
    send_one(16'h8000, 7'h00, 16'h8001, "sat_edge");
    send_one(16'hC000, 7'h7F, 16'h7FFF, "sat_clip");
  endtask

  task automatic test_rounding;
    rom_mode = 3;
`ifdef COS_POLY_ROUND_EN
    send_one(16'h0000, 7'h00, 16'h4001, "rounding");
`else
    send_one(16'h0000, 7'h00, 16'h4000, "rounding");
`endif
  endtask

  task automatic test_back_to_back;
    logic [15:0] vu  [0:7];
    logic [15:0] exp [0:7];
    int sent, recv;
    logic stalled_prev;
    logic [15:0] prev_cos;
    vu  = '{16'h0100, 16'h0080, 16'h0A04, 16'h40FF, 16'h8100, 16'hC07F, 16'h2080, 16'hE07A};
    exp = '{16'h0020, 16'h0010, 16'h0140, 16'hF820, 16'hFFE0, 16'h07F0, 16'h0410, 16'h03F0};
    sent = 0; recv = 0; stalled_prev = 1'b0; prev_cos = '0;
    rom_mode = 2;
    for (int c = 0; c < 40; c++) begin
      out_ready = !(c >= 6 && c < 11);
      in_valid  = (sent < 8);
      u         = (sent < 8) ? vu[sent] : 16'h0000;
      #1;
      if (!out_ready) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL bp in_ready during stall cycle %0d: got %0b want 0", c, in_ready);
        end
      end
      if (stalled_prev) begin
        checks++;
        if (out_valid !== 1'b1 || cos_out !== prev_cos) begin
          errors++; $display("FAIL bp hold cycle %0d: got v=%0b %h want v=1 %h", c, out_valid, cos_out, prev_cos);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (recv >= 8) begin
          errors++; $display("FAIL bp extra output: got %h want none", cos_out);
        end else if (cos_out !== exp[recv]) begin
          errors++; $display("FAIL bp sample %0d: got %h want %h", recv, cos_out, exp[recv]);
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      stalled_prev = out_valid && !out_ready;
      prev_cos     = cos_out;
      @(posedge clock); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv != 8 || sent != 8) begin
      errors++; $display("FAIL bp count: got sent=%0d recv=%0d want 8/8", sent, recv);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] seq [0:3];
    seq = '{16'h0000, 16'h4000, 16'h0000, 16'h4000};
    rom_mode  = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      u        = seq[i];
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid pre out_valid: got %0b want 1", out_valid);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid out_valid: got %0b want 0", out_valid); end
    checks++;
    if (cos_out !== 16'h0000) begin errors++; $display("FAIL rstmid cos_out: got %h want 0000", cos_out); end
    checks++;
    if (rom_addr !== 7'h00) begin errors++; $display("FAIL rstmid rom_addr: got %h want 00", rom_addr); end
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL rstmid residue cycle %0d: got %0b want 0", i, out_valid);
      end
    end
`ifdef COS_POLY_ROUND_EN
    send_one(16'h4000, 7'h7F, 16'hBFF8, "rstmid_restart");
`else
    send_one(16'h4000, 7'h7F, 16'hBFF9, "rstmid_restart");
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_mirror;
    test_saturation;
    test_rounding;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cos_poly_eval.md
Name: cos_poly_eval

Overview:
- Consumer side of the cosine coefficient ROM in the AWGN core's Box-Muller datapath.
- Accepts a 16-bit uniform phase word, folds it into the first quadrant and drives the 7-bit ROM address.
- Evaluates the degree-1 polynomial c0 + c1*xb from the ROM's registered coefficients.
- Emits a signed Q1.15 cos(2*pi*u) sample over a valid/ready stream.

Parameters:
- ROUND_BITS, 4, right-shift applied to the accumulated sum to form the 15-bit magnitude. Fixed at 4 for the current ROM format.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  phase word valid
- in_ready  out  1  block can accept a phase word this cycle
- u  in  16  phase: [15:14] quadrant q, [13:7] segment, [6:0] offset xb
- rom_addr  out  7  coefficient ROM read address (combinational)
- rom_c1  in  12  ROM slope coefficient, registered in ROM, 1-cycle latency
- rom_c0  in  19  ROM intercept coefficient, registered in ROM, 1-cycle latency
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- cos_out  out  16  signed Q1.15 result

Behaviour:
- Reset is asynchronous and active-high; clock is the single clock.
- Reset values: all stage valids 0, cos_out 0, out_valid 0, all pipeline registers 0 (so rom_addr is 0).
- Fold rules by quadrant q:
  - q odd (1, 3): mirror, addr = ~u[13:7], x = ~u[6:0].
  - q even (0, 2): addr = u[13:7], x = u[6:0].
  - Negate the result for q = 1 or 2.
- Pipeline: S1 holds addr, x, neg. S2 holds x, neg and addr aligned with ROM data. S3 holds the sum. S4 is the output register.
- Stall and handshake:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - An input is accepted on an edge where in_valid & in_ready.
  - On stall every stage holds its contents. Otherwise every stage advances, and bubbles propagate as valid = 0.
- rom_addr = stall ? S2.addr : S1.addr.
  - This keeps the ROM output equal to table(S2.addr) while stalled.
  - On an advance edge the ROM captures table(S1.addr) in step with S2 <= S1.
- S3 computation, on an advance edge, from the current rom_c1 and rom_c0:
  - p = rom_c1 * S2.x, 19-bit unsigned.
  - sum = {1'b0, rom_c0} + (p >> 4), 20-bit unsigned.
- S4 computation:
  - mag = sum[19] ? 15'h7FFF : sum[18:4], saturating.
  - cos_out = neg ? -{1'b0, mag} : {1'b0, mag}, two's complement, so the range is ±0x7FFF and 0x8000 is never produced.
- Latency: an input accepted at edge k gives out_valid = 1 after edge k+3, with no stall.
- Throughput: 1 sample per clock.
- cos_out and out_valid stay stable while stalled.
- Simultaneous events: when in_valid and a stall release occur in the same cycle, no acceptance happens (in_ready was low that cycle); acceptance resumes the next cycle.
- Reset mid-operation: in-flight samples are discarded and the block restarts empty. No partial output is presented.

Optional Feature:
- Macro: COS_POLY_ROUND_EN.
- Defined: S4 uses sum + 20'd8 before the shift (round half up), with the saturation check applied after the rounding add.
- Undefined: truncation as above. Latency is identical in both builds.

Test Plan:
- Basic path. Bench ROM constant c1 = 0x010, c0 = 0x40000, 1-cycle registered; u = 0x0000.
  -> rom_addr = 0x00; cos_out = 0x4000 three cycles after acceptance.
- Mirror and negate. Same ROM; u = 0x4000.
  -> rom_addr = 0x7F; sum = 0x4007F; cos_out = 0xBFF9.
- Saturation. ROM c1 = 0xFFF, c0 = 0x7FFFF; u = 0x8000 (q = 2, xb = 0 gives sum 0x7FFFF, so no saturation).
  -> cos_out = 0x8001.
  - Then u = 0xC000 (xb mirrored to 0x7F, sum > 2^19): the result saturates, so cos_out = 0x7FFF.
- Rounding. ROM c1 = 0, c0 = 0x40008; u = 0x0000.
  -> cos_out = 0x4000 without COS_POLY_ROUND_EN, 0x4001 with it.
- Backpressure. Address-dependent ROM (c0 = addr << 8), stream 8 consecutive u values, hold out_ready low for 5 cycles mid-stream.
  -> in_ready low throughout the stall; outputs in order; no drop or duplicate; each value matches the model.
- Reset mid-operation. Assert reset with 3 samples in flight.
  -> out_valid = 0 and cos_out = 0 immediately; after release, the first new sample appears exactly 3 cycles after acceptance.
